// File: rtl/block_buf_ctrl.sv
// Four-slot 8x8 block buffer: packs raster-order byte samples into a 64-word RAM
// and streams each stored block back out as sixteen little-endian 32-bit words.
module block_buf_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_last_o,
    output logic        ram_wr_en_o,
    output logic [3:0]  ram_ben_o,
    output logic [31:0] ram_wr_data_o,
    output logic [5:0]  ram_wr_addr_o,
    output logic        ram_rd_en_o,
    output logic [5:0]  ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i,
    output logic [2:0]  occupancy_o
);

    logic [1:0]  wr_slot;
    logic [5:0]  wr_idx;
    logic [1:0]  rd_slot;
    logic [3:0]  rd_word;
    logic [2:0]  occupancy;
    logic        rd_pending;
    logic        rd_pending_last;

    logic [31:0] fifo_data [2];
    logic        fifo_last [2];
    logic        fifo_head;
    logic [1:0]  fifo_count;

    logic        wr_accept;
    logic        rd_issue;
    logic        slot_done;
    logic        slot_release;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_tail;
    logic [2:0]  fifo_in_use;

    assign in_ready_o  = rst_i || (occupancy < 3'd4);
    assign wr_accept   = in_valid_i && in_ready_o && !rst_i;
    assign slot_done   = wr_accept && (wr_idx == 6'd63);

    assign ram_wr_en_o   = wr_accept;
    assign ram_wr_addr_o = {wr_slot, wr_idx[5:2]};
    assign ram_ben_o     = 4'b0001 << wr_idx[1:0];
    assign ram_wr_data_o = {4{in_data_i}};

    assign out_valid_o = (fifo_count != 2'd0) && !rst_i;
    assign fifo_pop    = out_valid_o && out_ready_i;
    assign fifo_push   = rd_pending;
    assign fifo_tail   = fifo_head ^ fifo_count[0];

    // Credit the word leaving this cycle so a steady stream reads back-to-back.
    assign fifo_in_use  = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, rd_pending};
    assign rd_issue     = !rst_i && (occupancy != 3'd0) && (fifo_in_use < 3'd2);
    assign slot_release = rd_issue && (rd_word == 4'd15);

    assign ram_rd_en_o   = rd_issue;
    assign ram_rd_addr_o = {rd_slot, rd_word};

    assign out_data_o  = out_valid_o ? fifo_data[fifo_head] : 32'd0;
    assign out_last_o  = out_valid_o && fifo_last[fifo_head];
    assign occupancy_o = rst_i ? 3'd0 : occupancy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_slot         <= 2'd0;
            wr_idx          <= 6'd0;
            rd_slot         <= 2'd0;
            rd_word         <= 4'd0;
            occupancy       <= 3'd0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            fifo_head       <= 1'b0;
            fifo_count      <= 2'd0;
        end else begin
            if (wr_accept) begin
                wr_idx <= wr_idx + 6'd1;
                if (slot_done) begin
                    wr_slot <= wr_slot + 2'd1;
                end
            end
            if (rd_issue) begin
                rd_word <= rd_word + 4'd1;
                if (slot_release) begin
                    rd_slot <= rd_slot + 2'd1;
                end
            end
            // A completion and a release in the same cycle cancel out.
            case ({slot_done, slot_release})
                2'b10:   occupancy <= occupancy + 3'd1;
                2'b01:   occupancy <= occupancy - 3'd1;
                default: occupancy <= occupancy;
            endcase
            rd_pending      <= rd_issue;
            rd_pending_last <= slot_release;
            fifo_head       <= fifo_head ^ fifo_pop;
            fifo_count      <= fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_data[fifo_tail] <= ram_rd_data_i;
            fifo_last[fifo_tail] <= rd_pending_last;
        end
    end

endmodule

// File: tb/tb_block_buf_ctrl.sv
// Randomized bench for block_buf_ctrl: a RAM model plus a sample-count based
// reference that predicts write addresses, read order, occupancy and output words.
module tb_block_buf_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        ram_wr_en_o;
    logic [3:0]  ram_ben_o;
    logic [31:0] ram_wr_data_o;
    logic [5:0]  ram_wr_addr_o;
    logic        ram_rd_en_o;
    logic [5:0]  ram_rd_addr_o;
    logic [31:0] ram_rd_data_i = 32'd0;
    logic [2:0]  occupancy_o;

    block_buf_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_ben_o(ram_ben_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_wr_addr_o(ram_wr_addr_o),
        .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
        .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] ram_model [64];

    always @(posedge clk_i) begin
        if (ram_wr_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_ben_o[b]) ram_model[ram_wr_addr_o][8*b +: 8] <= ram_wr_data_o[8*b +: 8];
            end
        end
        if (ram_rd_en_o) ram_rd_data_i <= ram_model[ram_rd_addr_o];
    end

    int          vector_count = 0;
    int          miss_count = 0;
    int          in_count = 0;
    int          rd_count = 0;
    int          out_count = 0;
    int          cycle_no = 0;
    int          first_rd_cycle = -1;
    int          first_out_cycle = -1;
    logic [31:0] first_word = 32'd0;
    logic [31:0] cur_word = 32'd0;
    logic [32:0] exp_q [$];
    bit          prev_stall = 0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    bit          last_release = 0;
    bit          seq_data = 0;
    logic [7:0]  seq_base = 8'd0;
    int          probe_idx = -1;
    bit          probe_hit = 0;
    logic [5:0]  probe_addr = 6'd0;
    logic [3:0]  probe_ben = 4'd0;
    logic [31:0] probe_data = 32'd0;
    logic [7:0]  probe_sample = 8'd0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus; the model advances by what the rules say happens at the next edge.
    task automatic applyStimulus(input bit v, input bit r);
        int         occ;
        bit         acc;
        logic [7:0] s;
        @(negedge clk_i);
        s = seq_data ? seq_base + 8'(in_count) : 8'($urandom);
        rst_i = 1'b0;
        in_valid_i = v;
        out_ready_i = r;
        in_data_i = s;
        #1;
        occ = in_count / 64 - rd_count / 16;
        checkOutput("in_ready", in_ready_o, occ < 4);
        checkOutput("occupancy", occupancy_o, occ);
        acc = v && (occ < 4);
        checkOutput("wr_en", ram_wr_en_o, acc);
        if (acc) begin
            checkOutput("wr_addr", ram_wr_addr_o, ((in_count / 64) % 4) * 16 + (in_count % 64) / 4);
            checkOutput("wr_ben", ram_ben_o, 1 << (in_count % 4));
            checkOutput("wr_data", ram_wr_data_o, {s, s, s, s});
            if (in_count == probe_idx) begin
                probe_hit = 1;
                probe_addr = ram_wr_addr_o;
                probe_ben = ram_ben_o;
                probe_data = ram_wr_data_o;
                probe_sample = s;
            end
            cur_word[8*(in_count % 4) +: 8] = s;
            if (in_count % 4 == 3) exp_q.push_back({(in_count % 64) == 63, cur_word});
            in_count++;
        end
        last_release = 0;
        if (ram_rd_en_o) begin
            checkOutput("rd_gate", occ > 0, 1);
            checkOutput("rd_addr", ram_rd_addr_o, rd_count % 64);
            if (first_rd_cycle < 0) first_rd_cycle = cycle_no;
            last_release = (rd_count % 16) == 15;
            rd_count++;
        end
        if (prev_stall) begin
            checkOutput("stall_valid", out_valid_o, 1);
            checkOutput("stall_data", {out_last_o, out_data_o}, {prev_last, prev_data});
        end
        if (out_valid_o && first_out_cycle < 0) begin
            first_out_cycle = cycle_no;
            first_word = out_data_o;
        end
        if (out_valid_o && r) begin
            checkOutput("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                checkOutput("out_word", {out_last_o, out_data_o}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            out_count++;
        end
        prev_stall = out_valid_o && !r;
        prev_data = out_data_o;
        prev_last = out_last_o;
        cycle_no++;
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            rst_i = 1'b1;
            in_valid_i = 1'b1;
            out_ready_i = 1'b1;
            #1;
            checkOutput("rst_in_ready", in_ready_o, 1);
            checkOutput("rst_out_valid", out_valid_o, 0);
            checkOutput("rst_out_last", out_last_o, 0);
            checkOutput("rst_out_data", out_data_o, 0);
            checkOutput("rst_wr_en", ram_wr_en_o, 0);
            checkOutput("rst_rd_en", ram_rd_en_o, 0);
            checkOutput("rst_occupancy", occupancy_o, 0);
        end
        in_count = 0;
        rd_count = 0;
        exp_q.delete();
        prev_stall = 0;
        first_rd_cycle = -1;
        first_out_cycle = -1;
        first_word = 32'd0;
        cycle_no = 0;
    endtask

    task automatic feed(input int target, input int pv, input int pr, input int limit);
        int n = 0;
        while (in_count < target && n < limit) begin
            applyStimulus($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
            n++;
        end
        checkOutput("feed_done", in_count, target);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        checkOutput("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        int o0;
        int n;
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        in_data_i = 8'd0;
        doReset(2);

        // Ascending ramp: packing order, last flag and read-to-output latency.
        seq_data = 1;
        seq_base = 8'h00;
        feed(64, 100, 100, 200);
        drain(100);
        checkOutput("first_word", first_word, 32'h03020100);
        checkOutput("first_latency", first_out_cycle - first_rd_cycle, 2);

        // Output blocked: capacity stops at four blocks, one release reopens input.
        doReset(1);
        feed(256, 100, 0, 400);
        repeat (4) applyStimulus(1'b1, 1'b0);
        checkOutput("cap_count", in_count, 256);
        checkOutput("cap_ready", in_ready_o, 0);
        checkOutput("cap_occupancy", occupancy_o, 4);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end while (!last_release && n < 50);
        checkOutput("release_seen", last_release, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ready_after_release", in_ready_o, 1);
        feed(320, 100, 100, 400);
        drain(200);

        // Full buffer with both sides streaming: back-to-back words, ten blocks total.
        doReset(1);
        seq_data = 0;
        feed(256, 100, 0, 400);
        repeat (4) applyStimulus(1'b1, 1'b1);
        o0 = out_count;
        repeat (32) applyStimulus(1'b1, 1'b1);
        checkOutput("burst_rate", out_count - o0, 32);
        feed(640, 100, 100, 2000);
        drain(200);

        // Random handshakes on both sides, twenty blocks.
        doReset(1);
        feed(1280, 50, 50, 12000);
        drain(400);

        // Reset with one stored block and a partial one pending.
        doReset(1);
        feed(101, 100, 0, 300);
        doReset(1);
        seq_data = 1;
        seq_base = 8'h80;
        feed(64, 100, 100, 200);
        drain(100);
        checkOutput("post_reset_word", first_word, 32'h83828180);

        // Write-port probe at sample 5 of slot 2.
        doReset(1);
        seq_data = 0;
        probe_idx = 133;
        feed(134, 100, 100, 400);
        checkOutput("probe_hit", probe_hit, 1);
        checkOutput("probe_addr", probe_addr, 6'h21);
        checkOutput("probe_ben", probe_ben, 4'b0010);
        checkOutput("probe_data", probe_data, {probe_sample, probe_sample, probe_sample, probe_sample});
        feed(192, 100, 100, 200);
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/block_buf_ctrl.md
BLOCK_BUF_CTRL -- requirements
Module: block_buf_ctrl

Interface
REQ-001 SHALL have no parameters; geometry fixed: 4 slots x 16 words x 32 bit (64-word RAM), one 8x8 block of 8-bit samples per slot.
REQ-002 clk_i  input  1  single clock; all logic rising-edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 in_data_i  input  8  pixel sample, raster order within 8x8 block.
REQ-005 in_valid_i  input  1  sample valid.
REQ-006 in_ready_o  output  1  sample accepted when in_valid_i & in_ready_o.
REQ-007 out_data_o  output  32  packed word: byte n%4 = sample n, little-endian lanes.
REQ-008 out_valid_o  output  1  word valid.
REQ-009 out_ready_i  input  1  word consumed when out_valid_o & out_ready_i.
REQ-010 out_last_o  output  1  high with 16th word of a block.
REQ-011 ram_wr_en_o / ram_ben_o[3:0] / ram_wr_data_o[31:0] / ram_wr_addr_o[5:0]  output  RAM write port.
REQ-012 ram_rd_en_o / ram_rd_addr_o[5:0]  output; ram_rd_data_i[31:0]  input  RAM read port, data valid the cycle after ram_rd_en_o, unregistered output.
REQ-013 occupancy_o  output  3  number of fully written, not yet released slots (0..4).

Function
REQ-014 Write: each accepted sample drives, same cycle, ram_wr_en_o=1, ram_wr_addr_o={wr_slot,wr_idx[5:2]}, ram_ben_o=one-hot(wr_idx[1:0]), ram_wr_data_o=sample replicated in all 4 lanes.
REQ-015 wr_idx 6-bit counts 0..63; on accept of wr_idx==63 it wraps to 0, wr_slot increments mod 4, and occupancy increments at that edge.
REQ-016 in_ready_o = (occupancy < 4) combinationally; no write issued when in_ready_o=0; ram_wr_en_o=0 when no accept.
REQ-017 Read: issue ram_rd_en_o=1, ram_rd_addr_o={rd_slot,rd_word} when occupancy>0 and (out-buffer count + in-flight reads) < 2.
REQ-018 rd_word 4-bit counts 0..15; on issue of rd_word==15, wrap to 0, rd_slot increments mod 4, slot released: occupancy decrements at that edge.
REQ-019 Simultaneous slot completion (REQ-015) and release (REQ-018) in one cycle SHALL leave occupancy unchanged.
REQ-020 Read of a slot SHALL NOT issue before the cycle after its 64th write; writes into a released slot may begin the cycle after release.
REQ-021 Returned read data and its last tag (rd_word==15 at issue) SHALL enter a 2-entry FIFO; out_data_o/out_last_o present the head; out_valid_o = FIFO non-empty.
REQ-022 Output SHALL never drop or duplicate a word under arbitrary out_ready_i; out_data_o/out_last_o stable while out_valid_o & ~out_ready_i.
REQ-023 Throughput: with in_valid_i and out_ready_i held high, one sample per cycle in and, after fill, one word per cycle out with no bubbles in the read path.
REQ-024 Block order out = block order in; word order within block = address order.

Reset
REQ-025 On rst_i=1 at an edge: wr_slot, wr_idx, rd_slot, rd_word, occupancy, FIFO count, in-flight flag = 0.
REQ-026 During and after reset: in_ready_o=1 (occupancy 0), out_valid_o=0, out_last_o=0, out_data_o=0, ram_wr_en_o=0, ram_rd_en_o=0, occupancy_o=0.
REQ-027 Reset mid-block SHALL discard partial and stored blocks; a read returning in the cycle after reset SHALL be dropped; RAM contents not cleared.

Verification
REQ-028 Samples 0x00..0x3F, out_ready_i=1 -> 16 words 0x03020100, 0x07060504, ..., 0x3F3E3D3C; out_last_o only on 16th; first word out 2 cycles after first read issue.
REQ-029 out_ready_i=0, feed 5 blocks -> 256 samples accepted, in_ready_o=0 after 256th, occupancy_o=4; raise out_ready_i -> in_ready_o=1 the cycle after 16th read issued.
REQ-030 Full with 4 slots, continuous in/out -> occupancy_o steady at 3/4 across simultaneous complete/release cycles; no sample lost over 10 blocks.
REQ-031 Random out_ready_i (50%) and in_valid_i (50%), 20 blocks -> scoreboard matches byte-exact, no duplicate/drop, data stable while stalled.
REQ-032 rst_i pulse after 37 samples and 1 buffered block -> outputs per REQ-026; next block 0x80..0xBF emits first word 0x83828180 from slot 0.
REQ-033 Write-port check: sample index 5 of slot 2 -> ram_wr_addr_o=0x21, ram_ben_o=0b0010, ram_wr_data_o=sample x4.
